// File: rtl/spi_io_pkg.sv
// Shared types and constants for the IO SPI master.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, instruction opcodes, and a helper that turns
// a cycle count into the terminal value of a zero-based counter.
package spi_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    INST,
    GAP,
    DATA,
    HOLD,
    IDLEWAIT
  } state_t;

  localparam logic [7:0] INST_WR = 8'h02;
  localparam logic [7:0] INST_RD = 8'h01;

  // Terminal count for a phase lasting n cycles; a zero-length phase still
  // spends one cycle in its state, so it clamps to 0.
  function automatic logic [15:0] last_cnt(input int n);
    return (n > 0) ? 16'(n - 1) : 16'd0;
  endfunction

endpackage

// File: rtl/spi_mst_shifter.sv
// 8-bit parallel-load shift register for the SPI master (tx MSB first, rx into LSB).
// Latency: load/shift/sample take effect on the next clk edge.
// Backpressure: none; strobes are obeyed every cycle, load wins over shift.
//
// Ports: clk, rst (async active-low); load + load_dat (parallel load, clears cnt);
//   shift (advance tx on sclk fall); sample + sdi (shift rx at end of sclk high);
//   sdo (tx MSB); rx_dat (received byte); cnt (bits shifted in current byte);
//   byte_done (this shift strobe completes the byte; cnt wraps 7->0).
module spi_mst_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_dat,
  input  logic       shift,
  input  logic       sample,
  input  logic       sdi,
  output logic       sdo,
  output logic [7:0] rx_dat,
  output logic [2:0] cnt,
  output logic       byte_done
);

  logic [7:0] tx_q;
  logic [7:0] rx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q <= 8'h00;
      rx_q <= 8'h00;
      cnt  <= 3'd0;
    end else begin
      if (load) begin
        tx_q <= load_dat;
        cnt  <= 3'd0;
      end else if (shift) begin
        tx_q <= {tx_q[6:0], 1'b0};
        cnt  <= cnt + 3'd1;
      end
      if (sample) begin
        rx_q <= {rx_q[6:0], sdi};
      end
    end
  end

  assign sdo       = tx_q[7];
  assign rx_dat    = rx_q;
  assign byte_done = shift && (cnt == 3'd7);

endmodule

// File: rtl/spi_io_master.sv
// SPI mode-0 master: one cs-framed {instruction, gap, data} transaction per command.
// Latency: cs_n low for 34*CLK_DIV+GAP_CYC cycles; done pulses the cycle cs_n rises.
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is ignored, host must hold it.
//
// Ports: clk, rst (async active-low); cmd_valid/cmd_ready/cmd_wr/cmd_wdata (command port);
//   done/done_rd/rdata (completion, rdata only updated by reads); busy;
//   sclk/cs_n/mosi/miso (SPI pins); dreq (only when SPI_IO_MASTER_DREQ_EN is defined:
//   slave data request, self-issues a read from IDLE when no host command is present).
module spi_io_master
  import spi_io_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int GAP_CYC     = 8,
  parameter int CS_IDLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_wdata,
  output logic       done,
  output logic       done_rd,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
`ifdef SPI_IO_MASTER_DREQ_EN
  ,
  input  logic       dreq
`endif
);

  localparam logic [15:0] DIV_LAST = last_cnt(CLK_DIV);
  localparam logic [15:0] GAP_LAST = last_cnt(GAP_CYC);
  localparam logic [15:0] IW_LAST  = last_cnt(CS_IDLE_CYC);

  state_t      state, state_nxt;
  logic [15:0] tmr;
  logic        hi;
  logic        wr_q;
  logic [7:0]  wdata_q;

  logic        start, start_wr;
  logic [7:0]  start_wdata;
  logic        xfer, half_end, fall, per_end, done_set;

  logic        sh_load, sh_shift, sh_sample, sdo, byte_done;
  logic [7:0]  sh_load_dat, rx_dat;
  logic [2:0]  bit_cnt;

  // Transaction source: host command first, then (optionally) slave request.
  always_comb begin
    start       = cmd_valid;
    start_wr    = cmd_wr;
    start_wdata = cmd_wdata;
`ifdef SPI_IO_MASTER_DREQ_EN
    if (!cmd_valid && dreq) begin
      start       = 1'b1;
      start_wr    = 1'b0;
      start_wdata = 8'h00;
    end
`endif
  end

  // sclk divider: tmr counts within a half period, hi selects the half.
  assign xfer     = (state == INST) || (state == DATA);
  assign half_end = xfer && (tmr == DIV_LAST);
  assign fall     = half_end && hi;
  assign per_end  = half_end && !hi;

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = SETUP;
      SETUP:    if (tmr == DIV_LAST) state_nxt = INST;
      // bit_cnt is only 0 in a low phase after the eighth fall has wrapped it.
      INST:     if (per_end && bit_cnt == 3'd0) state_nxt = (GAP_CYC > 0) ? GAP : DATA;
      GAP:      if (tmr == GAP_LAST) state_nxt = DATA;
      DATA:     if (per_end && bit_cnt == 3'd0) state_nxt = HOLD;
      HOLD: begin
        if (tmr == DIV_LAST) begin
          state_nxt = IDLEWAIT;
          done_set  = 1'b1;
        end
      end
      IDLEWAIT: if (tmr == IW_LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // At a byte boundary the fall loads the next byte instead of shifting, so the
  // data MSB sits on mosi through the gap; after the data byte mosi returns to 0.
  always_comb begin
    sh_shift    = fall;
    sh_sample   = fall && (state == DATA);
    sh_load     = ((state == IDLE) && start) || (fall && byte_done);
    sh_load_dat = 8'h00;
    if (state == IDLE) begin
      sh_load_dat = start_wr ? INST_WR : INST_RD;
    end else if (state == INST) begin
      sh_load_dat = wr_q ? wdata_q : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tmr     <= 16'd0;
      hi      <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      done    <= 1'b0;
      done_rd <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == IDLE || state_nxt != state || half_end) begin
        tmr <= 16'd0;
      end else begin
        tmr <= tmr + 16'd1;
      end
      // Every shifted byte opens with an sclk high phase.
      if (state_nxt != state) begin
        hi <= 1'b1;
      end else if (half_end) begin
        hi <= ~hi;
      end
      if (state == IDLE && start) begin
        wr_q    <= start_wr;
        wdata_q <= start_wdata;
      end
      done    <= done_set;
      done_rd <= done_set && !wr_q;
      if (done_set && !wr_q) begin
        rdata <= rx_dat;
      end
    end
  end

  spi_mst_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_dat  (sh_load_dat),
    .shift     (sh_shift),
    .sample    (sh_sample),
    .sdi       (miso),
    .sdo       (sdo),
    .rx_dat    (rx_dat),
    .cnt       (bit_cnt),
    .byte_done (byte_done)
  );

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign cs_n      = (state == IDLE) || (state == IDLEWAIT);
  assign sclk      = xfer && hi;
  assign mosi      = !cs_n && sdo;

endmodule

// File: tb/tb_spi_io_master.sv
// Bench for spi_io_master: default instance (0) and CLK_DIV=2/GAP_CYC=0 instance (1).
// Latency: n/a.
// Backpressure: stimulus waits for cmd_ready; expectations queue until done.
module tb_spi_io_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       cv[2], cw[2];
  logic [7:0] cd[2];
  logic       rdy[2], dn[2], dnrd[2], bsy[2], sck[2], csn[2], mo[2], mi[2];
  logic [7:0] rdo[2];
  logic       dreq0, dreq1;

  typedef struct {
    logic [15:0] bits;
    logic        rd;
    logic [7:0]  rdata;
    int          cslow;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;

  // Slave model state: byte returned on reads and sclk falls seen this frame.
  logic [7:0] slave[2];
  int         falls[2];
  logic [7:0] last_rd[2];

  // Monitor state.
  logic [15:0] m_bits[2];
  int          m_nbits[2], m_cslow[2], m_cshi[2], m_cyc[2], m_lastrise[2];
  logic        m_sprev[2], m_csprev[2], m_rdybad[2], m_perbad[2];

  function automatic logic miso_bit(input int f, input logic [7:0] b);
    if (f >= 8 && f < 16) return b[15 - f];
    return 1'b0;
  endfunction

  assign mi[0] = miso_bit(falls[0], slave[0]);
  assign mi[1] = miso_bit(falls[1], slave[1]);

  spi_io_master u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cv[0]), .cmd_ready(rdy[0]), .cmd_wr(cw[0]),
    .cmd_wdata(cd[0]), .done(dn[0]), .done_rd(dnrd[0]), .rdata(rdo[0]), .busy(bsy[0]),
    .sclk(sck[0]), .cs_n(csn[0]), .mosi(mo[0]), .miso(mi[0])
`ifdef SPI_IO_MASTER_DREQ_EN
    , .dreq(dreq0)
`endif
  );

  spi_io_master #(.CLK_DIV(2), .GAP_CYC(0), .CS_IDLE_CYC(4)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cv[1]), .cmd_ready(rdy[1]), .cmd_wr(cw[1]),
    .cmd_wdata(cd[1]), .done(dn[1]), .done_rd(dnrd[1]), .rdata(rdo[1]), .busy(bsy[1]),
    .sclk(sck[1]), .cs_n(csn[1]), .mosi(mo[1]), .miso(mi[1])
`ifdef SPI_IO_MASTER_DREQ_EN
    , .dreq(dreq1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input int div, input int gap,
                     input logic s, input logic c, input logic m, input logic dn_,
                     input logic dr_, input logic [7:0] r, input logic ry);
    exp_t e;
    int   qs;
    if (!rst) begin
      m_bits[d] = 16'h0; m_nbits[d] = 0; m_cslow[d] = 0; m_cshi[d] = 1000;
      m_cyc[d] = 0; m_lastrise[d] = 0; m_sprev[d] = 1'b0; m_csprev[d] = 1'b1;
      m_rdybad[d] = 1'b0; m_perbad[d] = 1'b0; falls[d] = 0;
      return;
    end
    m_cyc[d]++;
    if (!c && m_csprev[d]) begin
      check($sformatf("cs_idle_gap%0d", d), 32'(m_cshi[d] >= 4), 32'd1);
      m_cshi[d] = 0; m_bits[d] = 16'h0; m_nbits[d] = 0; m_cslow[d] = 0;
      m_rdybad[d] = 1'b0; m_perbad[d] = 1'b0; falls[d] = 0;
    end
    if (c) m_cshi[d]++;
    else begin
      m_cslow[d]++;
      if (ry) m_rdybad[d] = 1'b1;
    end
    if (s && !m_sprev[d]) begin
      if (m_nbits[d] > 0 && gap == 0 && (m_cyc[d] - m_lastrise[d]) != 2 * div) m_perbad[d] = 1'b1;
      m_lastrise[d] = m_cyc[d];
      m_bits[d] = {m_bits[d][14:0], m};
      m_nbits[d]++;
    end
    if (!s && m_sprev[d]) falls[d]++;
    m_sprev[d]  = s;
    m_csprev[d] = c;
    if (dn_) begin
      qs = (d == 0) ? q0.size() : q1.size();
      check($sformatf("sb_nonempty%0d", d), 32'(qs > 0), 32'd1);
      if (qs > 0) begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("mosi_bits%0d", d), 32'(m_bits[d]), 32'(e.bits));
        check($sformatf("nbits%0d", d), m_nbits[d], 32'd16);
        check($sformatf("done_rd%0d", d), 32'(dr_), 32'(e.rd));
        check($sformatf("rdata%0d", d), 32'(r), 32'(e.rdata));
        check($sformatf("cs_low%0d", d), m_cslow[d], e.cslow);
        check($sformatf("ready_low%0d", d), 32'(m_rdybad[d]), 32'd0);
        if (gap == 0) check($sformatf("sclk_period%0d", d), 32'(m_perbad[d]), 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 4, 8, sck[0], csn[0], mo[0], dn[0], dnrd[0], rdo[0], rdy[0]);
    mon(1, 2, 0, sck[1], csn[1], mo[1], dn[1], dnrd[1], rdo[1], rdy[1]);
  end

  task automatic push_exp(input int d, input logic wr, input logic [7:0] wd, input logic [7:0] sb);
    exp_t e;
    if (!wr) last_rd[d] = sb;
    e.bits  = {(wr ? 8'h02 : 8'h01), (wr ? wd : 8'h00)};
    e.rd    = !wr;
    e.rdata = last_rd[d];
    e.cslow = (d == 0) ? 144 : 68;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic issue(input int d, input logic wr, input logic [7:0] wd, input logic [7:0] sb);
    int n = 0;
    @(negedge clk);
    while (!rdy[d] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("issue_ready%0d", d), 32'(rdy[d]), 32'd1);
    slave[d] = sb;
    push_exp(d, wr, wd, sb);
    cv[d] = 1'b1; cw[d] = wr; cd[d] = wd;
    @(negedge clk);
    cv[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while ((((d == 0) ? q0.size() : q1.size()) != 0 || !rdy[d]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("idle_timeout%0d", d), 32'(n < 5000), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cv[i] = 1'b0; cw[i] = 1'b0; cd[i] = 8'h00; slave[i] = 8'h00; last_rd[i] = 8'h00;
    end
    dreq0 = 1'b0; dreq1 = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(rdy[0]), 32'd1);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_done", 32'(dn[0]), 32'd0);
    check("rst_done_rd", 32'(dnrd[0]), 32'd0);
    check("rst_rdata", 32'(rdo[0]), 32'h00);
    check("rst_sclk", 32'(sck[0]), 32'd0);
    check("rst_cs_n", 32'(csn[0]), 32'd1);
    check("rst_mosi", 32'(mo[0]), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Write, then read, at defaults.
    issue(0, 1'b1, 8'hA5, 8'h00);
    wait_idle(0);
    issue(0, 1'b0, 8'h00, 8'h3C);
    wait_idle(0);

    // Back-to-back write then read.
    issue(0, 1'b1, 8'h11, 8'h00);
    issue(0, 1'b0, 8'h00, 8'hF0);
    wait_idle(0);

    // Reset 40 cycles into a write.
    issue(0, 1'b1, 8'h77, 8'h00);
    repeat (38) @(negedge clk);
    check("pre_rst_cs_n", 32'(csn[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_cs_n", 32'(csn[0]), 32'd1);
    check("abort_sclk", 32'(sck[0]), 32'd0);
    check("abort_mosi", 32'(mo[0]), 32'd0);
    check("abort_ready", 32'(rdy[0]), 32'd1);
    check("abort_rdata", 32'(rdo[0]), 32'h00);
    q0.delete();
    q1.delete();
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(0, 1'b1, 8'h5C, 8'h00);
    wait_idle(0);
    issue(0, 1'b0, 8'h00, 8'hC3);
    wait_idle(0);

    // Fast divider, no gap.
    issue(1, 1'b1, 8'hFF, 8'h00);
    wait_idle(1);
    issue(1, 1'b0, 8'h00, 8'h96);
    wait_idle(1);

`ifdef SPI_IO_MASTER_DREQ_EN
    begin
      int n;
      // Self-issued read on dreq.
      slave[0] = 8'h5A;
      push_exp(0, 1'b0, 8'h00, 8'h5A);
      @(negedge clk);
      dreq0 = 1'b1;
      @(negedge clk);
      dreq0 = 1'b0;
      wait_idle(0);
      // Host write and dreq together: write goes first, read follows.
      push_exp(0, 1'b1, 8'h01, 8'h00);
      push_exp(0, 1'b0, 8'h00, 8'h5A);
      cv[0] = 1'b1; cw[0] = 1'b1; cd[0] = 8'h01; dreq0 = 1'b1;
      @(negedge clk);
      cv[0] = 1'b0;
      n = 0;
      while (q0.size() > 1 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      while (!bsy[0] && n < 4000) begin
        @(negedge clk);
        n++;
      end
      check("dreq_second_start", 32'(bsy[0]), 32'd1);
      dreq0 = 1'b0;
      wait_idle(0);
    end
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
